timer_multi: RTL and testbench



---
 rtl/timer_multi.sv | 191 +++++++++++++++++++
 tb/tb_timer_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: multi-channel up-counting timer peripheral.
// Each channel has a prescaler, a compare value, one-shot/periodic mode and a
// write-1-to-clear pending flag. Enabled pending flags are ORed onto int_sig_o.
// Register access uses a valid/ready request channel with a registered response.
module timer_multi #(
    parameter int CH_NUM  = 4,
    parameter int TIMER_W = 32,
    parameter int PSC_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        int_sig_o
);

    localparam logic [7:0] STATUS_ADDR = 8'h80;
    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_VALUE   = 4'h8;

    // Per-channel architectural state
    logic [CH_NUM-1:0]  r_en;
    logic [CH_NUM-1:0]  r_int_en;
    logic [CH_NUM-1:0]  r_pend;
    logic [CH_NUM-1:0]  r_mode;
    logic [PSC_W-1:0]   r_psc     [CH_NUM];
    logic [PSC_W-1:0]   r_psc_cnt [CH_NUM];
    logic [TIMER_W-1:0] r_count   [CH_NUM];
    logic [TIMER_W-1:0] r_value   [CH_NUM];

    // Bus response state
    logic               r_rsp_valid;
    logic [31:0]        r_data;

    // Decode and per-channel combinational terms
    logic               w_accept;
    logic               w_wr;
    logic [7:0]         w_addr;
    logic [2:0]         w_ch;
    logic               w_is_ch;
    logic               w_is_stat;
    logic               w_stat_wr;
    logic [CH_NUM-1:0]  w_tick;
    logic [CH_NUM-1:0]  w_expire;
    logic [CH_NUM-1:0]  w_ctrl_wr;
    logic [CH_NUM-1:0]  w_val_wr;
    logic [CH_NUM-1:0]  w_clr;
    logic [TIMER_W-1:0] w_val_new [CH_NUM];
    logic [31:0]        w_ch_word [CH_NUM];
    logic [31:0]        w_rdata;
    logic               w_unused_bits;

    assign req_ready_o = ~r_rsp_valid | rsp_ready_i;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_wr        = w_accept & we_i;
    assign w_addr      = addr_i[7:0];
    assign w_ch        = w_addr[6:4];
    assign w_is_ch     = ~w_addr[7] & (32'(w_ch) < 32'(CH_NUM));
    assign w_is_stat   = (w_addr == STATUS_ADDR);
    assign w_stat_wr   = w_wr & w_is_stat & sel_i[0];

    assign data_o      = r_data;
    assign rsp_valid_o = r_rsp_valid;
    // Interrupt is a pure function of registered state, so bus inputs cannot glitch it.
    assign int_sig_o   = |(r_pend & r_int_en);

    // Upper address bits are not decoded; data/strobe bits above the widest field are ignored.
    assign w_unused_bits = ^{addr_i[31:8], data_i, sel_i};

    // Per-channel tick/expiry, write strobes, byte-merged VALUE and read words
    always_comb begin
        w_tick    = {CH_NUM{1'b0}};
        w_expire  = {CH_NUM{1'b0}};
        w_ctrl_wr = {CH_NUM{1'b0}};
        w_val_wr  = {CH_NUM{1'b0}};
        w_clr     = {CH_NUM{1'b0}};
        for (int n = 0; n < CH_NUM; n++) begin
            w_tick[n]    = r_en[n] & (r_psc_cnt[n] == r_psc[n]);
            // Compare precedes increment, so the counter can never wrap.
            w_expire[n]  = w_tick[n] & (r_count[n] >= r_value[n]);
            w_ctrl_wr[n] = w_wr & w_is_ch & (w_ch == 3'(n)) & (w_addr[3:0] == OFF_CTRL);
            w_val_wr[n]  = w_wr & w_is_ch & (w_ch == 3'(n)) & (w_addr[3:0] == OFF_VALUE);
            w_clr[n]     = (w_ctrl_wr[n] & sel_i[0] & data_i[2]) | (w_stat_wr & data_i[n]);
            for (int b = 0; b < TIMER_W; b++) begin
                w_val_new[n][b] = sel_i[b / 8] ? data_i[b] : r_value[n][b];
            end
            case (w_addr[3:0])
                OFF_CTRL:  w_ch_word[n] = {16'd0, 8'(r_psc[n]), 4'd0,
                                           r_mode[n], r_pend[n], r_int_en[n], r_en[n]};
                OFF_COUNT: w_ch_word[n] = 32'(r_count[n]);
                OFF_VALUE: w_ch_word[n] = 32'(r_value[n]);
                default:   w_ch_word[n] = 32'd0;
            endcase
        end
    end

    // Read data mux: selected channel word, or the global pending status
    always_comb begin
        w_rdata = 32'd0;
        if (w_is_stat) begin
            for (int n = 0; n < CH_NUM; n++) begin
                w_rdata[n] = r_pend[n];
            end
        end else if (w_is_ch) begin
            for (int n = 0; n < CH_NUM; n++) begin
                w_rdata = w_rdata | ((w_ch == 3'(n)) ? w_ch_word[n] : 32'd0);
            end
        end else begin
            w_rdata = 32'd0;
        end
    end

    // Channel state: prescaler, counter, expiry and software register writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= {CH_NUM{1'b0}};
            r_int_en <= {CH_NUM{1'b0}};
            r_pend   <= {CH_NUM{1'b0}};
            r_mode   <= {CH_NUM{1'b0}};
            for (int n = 0; n < CH_NUM; n++) begin
                r_psc[n]     <= {PSC_W{1'b0}};
                r_psc_cnt[n] <= {PSC_W{1'b0}};
                r_count[n]   <= {TIMER_W{1'b0}};
                r_value[n]   <= {TIMER_W{1'b0}};
            end
        end else begin
            for (int n = 0; n < CH_NUM; n++) begin
                // Counting; a disabled channel holds both counters at zero.
                if (!r_en[n]) begin
                    r_psc_cnt[n] <= {PSC_W{1'b0}};
                    r_count[n]   <= {TIMER_W{1'b0}};
                end else if (w_tick[n]) begin
                    r_psc_cnt[n] <= {PSC_W{1'b0}};
                    r_count[n]   <= w_expire[n] ? {TIMER_W{1'b0}} : (r_count[n] + TIMER_W'(1'b1));
                end else begin
                    r_psc_cnt[n] <= r_psc_cnt[n] + PSC_W'(1'b1);
                end

                // Software write of en takes priority over one-shot self-disable.
                if (w_ctrl_wr[n] && sel_i[0]) begin
                    r_en[n]     <= data_i[0];
                    r_int_en[n] <= data_i[1];
                    r_mode[n]   <= data_i[3];
                    if (!data_i[0]) begin
                        r_psc_cnt[n] <= {PSC_W{1'b0}};
                        r_count[n]   <= {TIMER_W{1'b0}};
                    end
                end else if (w_expire[n] && !r_mode[n]) begin
                    r_en[n] <= 1'b0;
                end

                if (w_ctrl_wr[n] && sel_i[1]) begin
                    r_psc[n] <= data_i[8 +: PSC_W];
                end

                // Expiry beats a coincident write-1-to-clear.
                if (w_expire[n]) begin
                    r_pend[n] <= 1'b1;
                end else if (w_clr[n]) begin
                    r_pend[n] <= 1'b0;
                end

                if (w_val_wr[n]) begin
                    r_value[n] <= w_val_new[n];
                end
            end
        end
    end

    // Response channel: capture read data at acceptance, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_data      <= 32'd0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_data      <= w_wr ? 32'd0 : w_rdata;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi (4 channels, 16-bit timers, 8-bit prescale).
module tb_timer_multi;

    localparam int CH_NUM  = 4;
    localparam int TIMER_W = 16;
    localparam int PSC_W   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        int_sig_o;

    timer_multi #(.CH_NUM(CH_NUM), .TIMER_W(TIMER_W), .PSC_W(PSC_W)) dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .we_i(we_i), .data_o(data_o), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .int_sig_o(int_sig_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [31:0] expv;
    logic        ok;

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

    // One request, accepted at the next rising edge; returns response sampled 1ns later.
    task automatic bus_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic rok);
        int t;
        @(negedge clk);
        req_valid_i = 1'b1; we_i = we; addr_i = {24'd0, a}; data_i = d; sel_i = s;
        t = 0;
        while (!req_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0; we_i = 1'b0;
        rd  = data_o;
        rok = (t < 20) && rsp_valid_o;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_rd;
        logic        unused_ok;
        bus_xfer(1'b1, a, d, s, unused_rd, unused_ok);
    endtask

    task automatic test_reset();
        logic [7:0] a_tab [5] = '{8'h00, 8'h04, 8'h08, 8'h80, 8'h18};
        rst_n = 1'b0; req_valid_i = 1'b0; we_i = 1'b0; addr_i = 32'd0;
        data_i = 32'd0; sel_i = 4'h0; rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (data_o !== 32'd0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || int_sig_o !== 1'b0)
            $display("FAIL reset_outputs: got data=%h rv=%b rr=%b int=%b want 0/0/1/0",
                     data_o, rsp_valid_o, req_ready_o, int_sig_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'd0);
            bus_xfer(1'b0, a_tab[i], 32'd0, 4'h0, got, ok);
            expv = exp_q.pop_front(); n_checks++;
            if (!ok || got !== expv) $display("FAIL reset_reg_%0d: got %h want %h", i, got, expv);
            else n_pass++;
        end
    endtask

    task automatic test_periodic();
        wr(8'h08, 32'd4, 4'hF);
        wr(8'h00, 32'h0000_000B, 4'h1);           // enable at edge E
        for (int i = 0; i < 6; i++) begin         // reads at E+1..E+6
            exp_q.push_back(32'(i % 5));
            bus_xfer(1'b0, 8'h04, 32'd0, 4'h0, got, ok);
            expv = exp_q.pop_front(); n_checks++;
            if (!ok || got !== expv) $display("FAIL periodic_count_%0d: got %h want %h", i, got, expv);
            else n_pass++;
        end
        n_checks++;
        if (int_sig_o !== 1'b1) $display("FAIL periodic_int_rise: got %b want 1", int_sig_o);
        else n_pass++;
        exp_q.push_back(32'h0000_000F);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL periodic_ctrl_pend: got %h want %h", got, expv);
        else n_pass++;
        wr(8'h00, 32'h0000_000F, 4'h1);           // W1C at E+8, en stays set
        exp_q.push_back(32'h0000_000B);
        bus_xfer(1'b0, 8'h00, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL periodic_w1c_ctrl: got %h want %h", got, expv);
        else n_pass++;
        n_checks++;
        if (int_sig_o !== 1'b0) $display("FAIL periodic_int_cleared: got %b want 0", int_sig_o);
        else n_pass++;
        @(posedge clk);                            // E+10: next expiry
        #1;
        n_checks++;
        if (int_sig_o !== 1'b1) $display("FAIL periodic_int_again: got %b want 1", int_sig_o);
        else n_pass++;
        wr(8'h00, 32'h0000_0004, 4'h1);
        wr(8'h80, 32'h0000_000F, 4'h1);
        n_checks++;
        if (int_sig_o !== 1'b0) $display("FAIL periodic_stop_int: got %b want 0", int_sig_o);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [7:0]  a_tab [4] = '{8'h10, 8'h10, 8'h14, 8'h80};
        logic [31:0] e_tab [4] = '{32'h0000_0301, 32'h0000_0304, 32'h0000_0000, 32'h0000_0002};
        wr(8'h18, 32'd2, 4'hF);
        wr(8'h10, 32'h0000_0301, 4'h3);           // enable at edge E, expiry due at E+12
        repeat (11) @(posedge clk);
        for (int i = 0; i < 4; i++) begin         // reads at E+12..E+15
            exp_q.push_back(e_tab[i]);
            bus_xfer(1'b0, a_tab[i], 32'd0, 4'h0, got, ok);
            expv = exp_q.pop_front(); n_checks++;
            if (!ok || got !== expv) $display("FAIL oneshot_%0d: got %h want %h", i, got, expv);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (int_sig_o !== 1'b0) $display("FAIL oneshot_no_int: got %b want 0", int_sig_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_w1c_race();
        wr(8'h00, 32'h0000_000B, 4'h1);           // E; ch0 expiries at E+5, E+10
        repeat (9) @(posedge clk);
        wr(8'h80, 32'h0000_0001, 4'h1);           // W1C coincides with expiry at E+10
        exp_q.push_back(32'h0000_0003);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL race_set_wins: got %h want %h", got, expv);
        else n_pass++;
        wr(8'h80, 32'h0000_0001, 4'h1);           // E+12, no expiry
        exp_q.push_back(32'h0000_0002);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL race_clear: got %h want %h", got, expv);
        else n_pass++;
        n_checks++;
        if (int_sig_o !== 1'b0) $display("FAIL race_int: got %b want 0", int_sig_o);
        else n_pass++;
        wr(8'h00, 32'h0000_0004, 4'h1);
        wr(8'h80, 32'h0000_000F, 4'h2);           // sel_i[0] low: ignored
        exp_q.push_back(32'h0000_0002);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL status_sel_gate: got %h want %h", got, expv);
        else n_pass++;
        wr(8'h80, 32'h0000_0002, 4'h1);
        exp_q.push_back(32'h0000_0000);
        bus_xfer(1'b0, 8'h80, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL status_cleared: got %h want %h", got, expv);
        else n_pass++;
    endtask

    task automatic test_bytes_map();
        logic [7:0]  wa [5] = '{8'h28, 8'h28, 8'h24, 8'h50, 8'h2C};
        logic [31:0] wd [5] = '{32'h0000_AB00, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_000B, 32'h5555_5555};
        logic [3:0]  ws [5] = '{4'h2, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [31:0] ev [5] = '{32'h0000_AB00, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 5; i++) begin
            wr(wa[i], wd[i], ws[i]);
            exp_q.push_back(ev[i]);
            bus_xfer(1'b0, wa[i], 32'd0, 4'h0, got, ok);
            expv = exp_q.pop_front(); n_checks++;
            if (!ok || got !== expv) $display("FAIL bytes_map_%0d: got %h want %h", i, got, expv);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        wr(8'h20, 32'h0000_0009, 4'h1);           // ch2 periodic, VALUE 0xFFFF, enable at E
        repeat (6) @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0; req_valid_i = 1'b1; we_i = 1'b0;
        addr_i = 32'h0000_0024; data_i = 32'd0; sel_i = 4'h0;
        exp_q.push_back(32'd6);                    // accepted at E+7 -> count after E+6
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        expv = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || data_o !== expv)
                $display("FAIL stall_hold_%0d: got rv=%b rr=%b data=%h want 1/0/%h",
                         k, rsp_valid_o, req_ready_o, data_o, expv);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rsp_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", req_ready_o);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid_o !== 1'b0) $display("FAIL stall_rsp_drop: got %b want 0", rsp_valid_o);
        else n_pass++;
        exp_q.push_back(32'd0);
        bus_xfer(1'b0, 8'h90, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL unmapped_90: got %h want %h", got, expv);
        else n_pass++;
        wr(8'h20, 32'h0000_0000, 4'h1);
    endtask

    task automatic test_reset_midrun();
        logic [7:0] a_tab [3] = '{8'h04, 8'h00, 8'h80};
        wr(8'h00, 32'h0000_000B, 4'h1);           // ch0 VALUE 4, enable at E
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (int_sig_o !== 1'b1) $display("FAIL midrun_int: got %b want 1", int_sig_o);
        else n_pass++;
        @(negedge clk);
        rsp_ready_i = 1'b0; req_valid_i = 1'b1; we_i = 1'b0;
        addr_i = 32'h0000_0004; data_i = 32'd0; sel_i = 4'h0;
        exp_q.push_back(32'd1);                    // accepted at E+7 -> count after E+6
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        expv = exp_q.pop_front(); n_checks++;
        if (rsp_valid_o !== 1'b1 || data_o !== expv)
            $display("FAIL midrun_read: got rv=%b data=%h want 1/%h", rsp_valid_o, data_o, expv);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_o !== 32'd0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || int_sig_o !== 1'b0)
            $display("FAIL midrun_reset: got data=%h rv=%b rr=%b int=%b want 0/0/1/0",
                     data_o, rsp_valid_o, req_ready_o, int_sig_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'd0);
            bus_xfer(1'b0, a_tab[i], 32'd0, 4'h0, got, ok);
            expv = exp_q.pop_front(); n_checks++;
            if (!ok || got !== expv) $display("FAIL after_reset_%0d: got %h want %h", i, got, expv);
            else n_pass++;
        end
        wr(8'h08, 32'd4, 4'hF);
        wr(8'h00, 32'h0000_000B, 4'h1);           // re-enable at E'
        repeat (2) @(posedge clk);
        exp_q.push_back(32'd2);                    // read at E'+3 -> count after E'+2
        bus_xfer(1'b0, 8'h04, 32'd0, 4'h0, got, ok);
        expv = exp_q.pop_front(); n_checks++;
        if (!ok || got !== expv) $display("FAIL reenable_count: got %h want %h", got, expv);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_w1c_race();
        test_bytes_map();
        test_stall();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
